// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - 8086-style multiplexed-bus I/O slave: NPORTS registered outputs, sampled inputs, wait states
// Decode, strobe sequencing and wait-state insertion live in one registered state machine.
module io_port_bank #(
  parameter int DW          = 8,
  parameter int AW          = 20,
  parameter int NPORTS      = 8,
  parameter int BASE        = 0,
  parameter int WAIT_STATES = 1,
  parameter int RESET_VAL   = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ALE,
  input  logic                 IOM,
  input  logic                 CS,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [AW-1:0]        Address,
  input  logic [DW-1:0]        DataIn,
  output logic [DW-1:0]        DataOut,
  output logic                 DataOE,
  output logic                 READY,
  input  logic [NPORTS*DW-1:0] PortIn,
  output logic [NPORTS*DW-1:0] PortOut,
  output logic [NPORTS-1:0]    WriteStrobe,
  output logic                 ErrFlag
);

  localparam int            IW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [AW-1:0] FIRST = AW'(BASE);
  localparam logic [AW-1:0] LAST  = AW'(BASE + NPORTS - 1);
  localparam logic [3:0]    WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          op_wr;
  logic [3:0]    cnt;
  logic [DW-1:0] hold;

  logic          hit;
  logic          strobe_held;
  logic          in_cycle;
  logic [DW-1:0] lane_in;

  always_comb begin
    hit         = ALE && IOM && CS && (Address >= FIRST) && (Address <= LAST);
    strobe_held = op_wr ? !WR : !RD;
    in_cycle    = (state == ST_WAIT) || (state == ST_READ) || (state == ST_WRITE);
    lane_in     = PortIn[idx*DW +: DW];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      idx         <= '0;
      op_wr       <= 1'b0;
      cnt         <= '0;
      hold        <= '0;
      PortOut     <= {NPORTS{DW'(RESET_VAL)}};
      DataOut     <= '0;
      DataOE      <= 1'b0;
      READY       <= 1'b1;
      WriteStrobe <= '0;
      ErrFlag     <= 1'b0;
    end else begin
      WriteStrobe <= '0;
      // Holding register tracks the bus so the commit uses the last WR-low sample.
      if (!WR) hold <= DataIn;

      if (in_cycle && ALE) begin
        // A new address phase inside an open cycle is a protocol error; it is not decoded.
        ErrFlag <= 1'b1;
        DataOE  <= 1'b0;
        DataOut <= '0;
        READY   <= 1'b1;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (hit) begin
              idx   <= IW'(Address - FIRST);
              state <= ST_ADDR;
            end
          end

          ST_ADDR: begin
            if (ALE) begin
              if (hit) idx <= IW'(Address - FIRST);
              else     state <= ST_IDLE;
            end else if (!RD && !WR) begin
              ErrFlag <= 1'b1;
              state   <= ST_IDLE;
            end else if (!RD || !WR) begin
              op_wr <= !WR;
              if (WAIT_STATES == 0) begin
                if (!WR) begin
                  state <= ST_WRITE;
                end else begin
                  state   <= ST_READ;
                  DataOut <= lane_in;
                  DataOE  <= 1'b1;
                end
              end else begin
                state <= ST_WAIT;
                cnt   <= WS;
                READY <= 1'b0;
              end
            end
          end

          ST_WAIT: begin
            if (!strobe_held) begin
              state <= ST_IDLE;
              READY <= 1'b1;
            end else if (cnt == 4'd1) begin
              READY <= 1'b1;
              if (op_wr) begin
                state <= ST_WRITE;
              end else begin
                state   <= ST_READ;
                DataOut <= lane_in;
                DataOE  <= 1'b1;
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          ST_READ: begin
            if (RD) begin
              state   <= ST_IDLE;
              DataOE  <= 1'b0;
              DataOut <= '0;
            end
          end

          ST_WRITE: begin
            if (WR) begin
              PortOut[idx*DW +: DW] <= hold;
              WriteStrobe[idx]      <= 1'b1;
              state                 <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - vector table, directed corner sequences and randomized transactions for io_port_bank
module tb_io_port_bank;

  localparam int NI = 4;

  logic        CLK     = 1'b0;
  logic        RESET   = 1'b1;
  logic        ALE     = 1'b0;
  logic        IOM     = 1'b0;
  logic        CS      = 1'b0;
  logic        RD      = 1'b1;
  logic        WR      = 1'b1;
  logic [19:0] Address = '0;
  logic [7:0]  DataIn  = '0;
  logic [63:0] pin     = '0;

  logic [7:0]  dout [NI];
  logic        oe   [NI];
  logic        rdy  [NI];
  logic        err  [NI];
  logic [63:0] pout [NI];
  logic [7:0]  wstb [NI];
  logic [31:0] pout1;
  logic [3:0]  wstb1;

  always #5 CLK = ~CLK;

  io_port_bank u0 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .CS(CS), .RD(RD), .WR(WR),
    .Address(Address), .DataIn(DataIn), .DataOut(dout[0]), .DataOE(oe[0]), .READY(rdy[0]),
    .PortIn(pin), .PortOut(pout[0]), .WriteStrobe(wstb[0]), .ErrFlag(err[0]));

  io_port_bank #(.BASE('h100), .NPORTS(4)) u1 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .CS(CS), .RD(RD), .WR(WR),
    .Address(Address), .DataIn(DataIn), .DataOut(dout[1]), .DataOE(oe[1]), .READY(rdy[1]),
    .PortIn(pin[31:0]), .PortOut(pout1), .WriteStrobe(wstb1), .ErrFlag(err[1]));
  assign pout[1] = {32'h0, pout1};
  assign wstb[1] = {4'h0, wstb1};

  io_port_bank #(.WAIT_STATES(0)) u2 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .CS(CS), .RD(RD), .WR(WR),
    .Address(Address), .DataIn(DataIn), .DataOut(dout[2]), .DataOE(oe[2]), .READY(rdy[2]),
    .PortIn(pin), .PortOut(pout[2]), .WriteStrobe(wstb[2]), .ErrFlag(err[2]));

  io_port_bank #(.WAIT_STATES(4), .RESET_VAL('h5A)) u3 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .CS(CS), .RD(RD), .WR(WR),
    .Address(Address), .DataIn(DataIn), .DataOut(dout[3]), .DataOE(oe[3]), .READY(rdy[3]),
    .PortIn(pin), .PortOut(pout[3]), .WriteStrobe(wstb[3]), .ErrFlag(err[3]));

  int         base_k [NI] = '{0, 'h100, 0, 0};
  int         np_k   [NI] = '{8, 4, 8, 8};
  int         ws_k   [NI] = '{1, 1, 0, 4};
  logic [7:0] rv_k   [NI] = '{8'h00, 8'h00, 8'h00, 8'h5A};

  // Transaction-level model: port contents and sticky error per instance.
  logic [7:0]  mem  [NI][8];
  bit          merr [NI];
  logic [63:0] pin_hist [16];
  logic [7:0]  last_wd;

  // Event monitor, sampled on the falling edge.
  int         rlow [NI];
  int         oecnt[NI];
  int         wcnt [NI];
  int         dchg [NI];
  logic [7:0] wlast [NI];
  logic [7:0] dfirst[NI];
  logic       oe_prev[NI];

  always @(negedge CLK) begin
    for (int k = 0; k < NI; k++) begin
      if (rdy[k] === 1'b0) rlow[k]++;
      if (oe[k] === 1'b1) begin
        if (oe_prev[k] !== 1'b1) dfirst[k] = dout[k];
        else if (dout[k] !== dfirst[k]) dchg[k]++;
        oecnt[k]++;
      end else if (dout[k] !== 8'h00) begin
        dchg[k]++;
      end
      if (wstb[k] !== 8'h00) begin
        wcnt[k]++;
        wlast[k] = wstb[k];
      end
      oe_prev[k] = oe[k];
    end
  end

  int nvec = 0;
  int nbad = 0;
  int s_rl[NI], s_oe[NI], s_wc[NI], s_dc[NI];
  int d_rl[NI], d_oe[NI], d_wc[NI], d_dc[NI];

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s[u%0d]: got %0h, want %0h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < NI; k++) begin
      s_rl[k] = rlow[k]; s_oe[k] = oecnt[k]; s_wc[k] = wcnt[k]; s_dc[k] = dchg[k];
    end
  endtask

  task automatic delta();
    for (int k = 0; k < NI; k++) begin
      d_rl[k] = rlow[k] - s_rl[k]; d_oe[k] = oecnt[k] - s_oe[k];
      d_wc[k] = wcnt[k] - s_wc[k]; d_dc[k] = dchg[k] - s_dc[k];
    end
  endtask

  function automatic logic [63:0] mpack(input int k);
    logic [63:0] p;
    p = '0;
    for (int j = 0; j < np_k[k]; j++) p[j*8 +: 8] = mem[k][j];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      merr[k] = 1'b0;
      for (int j = 0; j < 8; j++) mem[k][j] = rv_k[k];
    end
  endtask

  // op: 0 = read, 1 = write, 2 = both strobes low.
  task automatic model(input logic [19:0] a, input bit i, input bit c, input int op, input int len,
                       input logic [7:0] wd);
    for (int k = 0; k < NI; k++) begin
      bit         hit;
      bit         done;
      int         idx;
      int         e_rl;
      int         e_oe;
      int         e_wc;
      logic [7:0] e_mask;
      logic [7:0] e_d;
      hit    = i && c && (int'(a) >= base_k[k]) && (int'(a) < base_k[k] + np_k[k]);
      idx    = int'(a) - base_k[k];
      done   = len > ws_k[k];
      e_rl   = 0; e_oe = 0; e_wc = 0; e_mask = 8'h00; e_d = 8'h00;
      if (hit && op == 2) begin
        merr[k] = 1'b1;
      end else if (hit) begin
        e_rl = done ? ws_k[k] : len;
        if (op == 0 && done) begin
          e_oe = len - ws_k[k];
          e_d  = pin_hist[ws_k[k] + 1][idx*8 +: 8];
        end
        if (op == 1 && done) begin
          mem[k][idx] = wd;
          e_wc        = 1;
          e_mask      = 8'(1 << idx);
        end
      end
      chk("ready_low_cycles", k, 64'(d_rl[k]), 64'(e_rl));
      chk("oe_cycles", k, 64'(d_oe[k]), 64'(e_oe));
      chk("strobe_pulses", k, 64'(d_wc[k]), 64'(e_wc));
      chk("dataout_stability", k, 64'(d_dc[k]), 64'd0);
      if (e_oe > 0) chk("read_data", k, 64'(dfirst[k]), 64'(e_d));
      if (e_wc > 0) chk("strobe_lane", k, 64'(wlast[k]), 64'(e_mask));
      chk("port_out", k, pout[k], mpack(k));
      chk("err_flag", k, 64'(err[k]), 64'(merr[k]));
    end
  endtask

  task automatic bus(input logic [19:0] a, input bit i, input bit c, input int op, input int len,
                     input logic [7:0] d, input bit rnd);
    snap();
    ALE = 1'b1; Address = a; IOM = i; CS = c; RD = 1'b1; WR = 1'b1;
    tick();
    ALE = 1'b0; Address = 20'($urandom);
    for (int s = 1; s <= len; s++) begin
      RD     = !(op == 0 || op == 2);
      WR     = !(op == 1 || op == 2);
      DataIn = rnd ? 8'($urandom) : d;
      if (rnd) pin = {$urandom, $urandom};
      pin_hist[s] = pin;
      last_wd     = DataIn;
      tick();
    end
    RD = 1'b1; WR = 1'b1;
    tick();
    @(negedge CLK);
    #1;
    delta();
    model(a, i, c, op, len, last_wd);
  endtask

  typedef struct {
    logic [19:0] a;
    bit          iom;
    bit          cs;
    int          op;
    int          len;
    logic [7:0]  d;
    int          rl;
    int          oe;
    logic [7:0]  dout;
    logic [7:0]  mask;
    logic [63:0] pout;
    bit          err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Expectations below are for u0 (BASE 0, 8 ports, 1 wait state).
    tbl[0]  = '{20'h00003, 1, 1, 1, 3, 8'hA5, 1, 0, 8'h00, 8'h08, 64'h00000000_A5000000, 0};
    tbl[1]  = '{20'h00005, 1, 1, 0, 3, 8'h00, 1, 2, 8'h3C, 8'h00, 64'h00000000_A5000000, 0};
    tbl[2]  = '{20'h00104, 1, 1, 1, 2, 8'h11, 0, 0, 8'h00, 8'h00, 64'h00000000_A5000000, 0};
    tbl[3]  = '{20'h00103, 1, 1, 1, 2, 8'h77, 0, 0, 8'h00, 8'h00, 64'h00000000_A5000000, 0};
    tbl[4]  = '{20'h00002, 0, 1, 1, 2, 8'h99, 0, 0, 8'h00, 8'h00, 64'h00000000_A5000000, 0};
    tbl[5]  = '{20'h00002, 1, 0, 1, 2, 8'h99, 0, 0, 8'h00, 8'h00, 64'h00000000_A5000000, 0};
    tbl[6]  = '{20'h00007, 1, 1, 1, 1, 8'h5E, 1, 0, 8'h00, 8'h00, 64'h00000000_A5000000, 0};
    tbl[7]  = '{20'h00007, 1, 1, 1, 2, 8'h5E, 1, 0, 8'h00, 8'h80, 64'h5E000000_A5000000, 0};
    tbl[8]  = '{20'h00007, 1, 1, 0, 2, 8'h00, 1, 1, 8'h81, 8'h00, 64'h5E000000_A5000000, 0};
    tbl[9]  = '{20'h00008, 1, 1, 0, 3, 8'h00, 0, 0, 8'h00, 8'h00, 64'h5E000000_A5000000, 0};
    tbl[10] = '{20'h00100, 1, 1, 0, 2, 8'h00, 0, 0, 8'h00, 8'h00, 64'h5E000000_A5000000, 0};
    tbl[11] = '{20'h000FF, 1, 1, 0, 2, 8'h00, 0, 0, 8'h00, 8'h00, 64'h5E000000_A5000000, 0};
    tbl[12] = '{20'h00000, 1, 1, 0, 5, 8'h00, 1, 4, 8'h77, 8'h00, 64'h5E000000_A5000000, 0};
    tbl[13] = '{20'h00001, 1, 1, 0, 2, 8'h00, 1, 1, 8'h66, 8'h00, 64'h5E000000_A5000000, 0};
    tbl[14] = '{20'h00004, 1, 1, 2, 1, 8'h00, 0, 0, 8'h00, 8'h00, 64'h5E000000_A5000000, 1};
    tbl[15] = '{20'h00006, 1, 1, 1, 2, 8'hC0, 1, 0, 8'h00, 8'h40, 64'h5EC00000_A5000000, 1};

    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      chk("reset_ready", k, 64'(rdy[k]), 64'd1);
      chk("reset_oe", k, 64'(oe[k]), 64'd0);
      chk("reset_dataout", k, 64'(dout[k]), 64'd0);
      chk("reset_err", k, 64'(err[k]), 64'd0);
      chk("reset_strobe", k, 64'(wstb[k]), 64'd0);
      chk("reset_port_out", k, pout[k], mpack(k));
    end

    pin = 64'h8111_3C33_4455_6677;
    for (int n = 0; n < 16; n++) begin
      bus(tbl[n].a, tbl[n].iom, tbl[n].cs, tbl[n].op, tbl[n].len, tbl[n].d, 1'b0);
      chk($sformatf("tbl%0d_ready_low", n), 0, 64'(d_rl[0]), 64'(tbl[n].rl));
      chk($sformatf("tbl%0d_oe_cycles", n), 0, 64'(d_oe[0]), 64'(tbl[n].oe));
      if (tbl[n].oe > 0) chk($sformatf("tbl%0d_dataout", n), 0, 64'(dfirst[0]), 64'(tbl[n].dout));
      chk($sformatf("tbl%0d_strobe", n), 0, 64'((d_wc[0] > 0) ? wlast[0] : 8'h00), 64'(tbl[n].mask));
      chk($sformatf("tbl%0d_port_out", n), 0, pout[0], tbl[n].pout);
      chk($sformatf("tbl%0d_err", n), 0, 64'(err[0]), 64'(tbl[n].err));
    end

    // Reset asserted while a write strobe is still low: nothing commits.
    snap();
    ALE = 1'b1; Address = 20'h00002; IOM = 1'b1; CS = 1'b1;
    tick();
    ALE = 1'b0; WR = 1'b0; DataIn = 8'hE7;
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    model_reset();
    for (int k = 0; k < NI; k++) begin
      chk("rst_mid_ready", k, 64'(rdy[k]), 64'd1);
      chk("rst_mid_err", k, 64'(err[k]), 64'd0);
      chk("rst_mid_port_out", k, pout[k], mpack(k));
    end
    RESET = 1'b0; WR = 1'b1;
    tick();
    tick();
    delta();
    for (int k = 0; k < NI; k++) begin
      chk("rst_mid_no_strobe", k, 64'(d_wc[k]), 64'd0);
      chk("rst_mid_port_hold", k, pout[k], mpack(k));
    end

    // ALE arriving inside an open write (u3 is still in its wait states).
    snap();
    ALE = 1'b1; Address = 20'h00003; IOM = 1'b1; CS = 1'b1;
    tick();
    ALE = 1'b0; WR = 1'b0; DataIn = 8'h3E;
    repeat (3) tick();
    ALE = 1'b1; Address = 20'h00003;
    tick();
    ALE = 1'b0; WR = 1'b1;
    tick();
    tick();
    delta();
    for (int k = 0; k < NI; k++) begin
      if (k != 1) merr[k] = 1'b1;
      chk("ale_abort_no_strobe", k, 64'(d_wc[k]), 64'd0);
      chk("ale_abort_port_out", k, pout[k], mpack(k));
      chk("ale_abort_err", k, 64'(err[k]), 64'(merr[k]));
      chk("ale_abort_ready", k, 64'(rdy[k]), 64'd1);
      chk("ale_abort_oe", k, 64'(oe[k]), 64'd0);
    end
    bus(20'h00005, 1'b1, 1'b1, 1, 3, 8'h42, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [19:0] a;
      int          sel;
      int          op;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 20'($urandom_range(0, 9));
        1:       a = 20'('hFF + $urandom_range(0, 6));
        2:       a = 20'($urandom);
        default: a = 20'($urandom_range(0, 7));
      endcase
      op = ($urandom_range(0, 19) == 0) ? 2 : int'($urandom_range(0, 1));
      bus(a, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, op,
          int'($urandom_range(1, 7)), 8'h00, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
